// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchronized input, mid-bit sampling, framing
// error detection with a wait-for-idle recovery state.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Error,
    output logic       o_RX_Busy
);

    localparam int unsigned CNT_W = 13;
    localparam int unsigned IDX_W = 3;
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RX_START_BIT = 3'd1,
        RX_DATA_BITS = 3'd2,
        RX_STOP_BIT  = 3'd3,
        CLEANUP      = 3'd4,
        WAIT_IDLE    = 3'd5
    } state_t;

    logic             rx_meta;
    logic             rx_s;
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [IDX_W-1:0] bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic [7:0]       byte_next;
    logic             dv_next;
    logic             err_next;
    logic             busy_next;

    // State register, synchronizer and registered outputs
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            o_RX_Byte  <= 8'h00;
            o_RX_DV    <= 1'b0;
            o_RX_Error <= 1'b0;
            o_RX_Busy  <= 1'b0;
        end else begin
            rx_meta    <= i_RX_Serial;
            rx_s       <= rx_meta;
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_idx_next;
            shift      <= shift_next;
            o_RX_Byte  <= byte_next;
            o_RX_DV    <= dv_next;
            o_RX_Error <= err_next;
            o_RX_Busy  <= busy_next;
        end
    end

    // Next-state and next-output logic; pulses default low so they last one cycle
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        byte_next    = o_RX_Byte;
        dv_next      = 1'b0;
        err_next     = 1'b0;

        case (state)
            IDLE: begin
                cnt_next     = '0;
                bit_idx_next = '0;
                if (!rx_s) state_next = RX_START_BIT;
            end
            RX_START_BIT: begin
                if (cnt == HALF_BIT) begin
                    cnt_next   = '0;
                    state_next = rx_s ? IDLE : RX_DATA_BITS;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RX_DATA_BITS: begin
                if (cnt == LAST_CLK) begin
                    cnt_next            = '0;
                    shift_next[bit_idx] = rx_s;
                    if (bit_idx == IDX_W'(7)) begin
                        bit_idx_next = '0;
                        state_next   = RX_STOP_BIT;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RX_STOP_BIT: begin
                if (cnt == LAST_CLK) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        byte_next  = shift;
                        dv_next    = 1'b1;
                        state_next = CLEANUP;
                    end else begin
                        err_next   = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            CLEANUP: begin
                state_next = IDLE;
            end
            WAIT_IDLE: begin
                // Line must return high before a new start bit can be trusted
                if (rx_s) state_next = IDLE;
            end
            default: begin
                state_next   = IDLE;
                cnt_next     = '0;
                bit_idx_next = '0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed and random 8N1 frames checked
// against a frame-level model of expected bytes and framing errors.
module tb_uart_receiver;

    localparam int unsigned C16 = 16;
    localparam int unsigned C4  = 4;
    localparam int unsigned C8K = 8191;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst16, rst_ext;
    logic       rx16, rx4, rx8k;
    logic       dv16, err16, busy16;
    logic       dv4, err4, busy4;
    logic       dv8k, err8k, busy8k;
    logic [7:0] byte16, byte4, byte8k;

    uart_receiver #(.CLKS_PER_BIT(C16)) u16 (
        .i_Clock(clk), .i_Reset(rst16), .i_RX_Serial(rx16),
        .o_RX_DV(dv16), .o_RX_Byte(byte16), .o_RX_Error(err16), .o_RX_Busy(busy16)
    );
    uart_receiver #(.CLKS_PER_BIT(C4)) u4 (
        .i_Clock(clk), .i_Reset(rst_ext), .i_RX_Serial(rx4),
        .o_RX_DV(dv4), .o_RX_Byte(byte4), .o_RX_Error(err4), .o_RX_Busy(busy4)
    );
    uart_receiver #(.CLKS_PER_BIT(C8K)) u8k (
        .i_Clock(clk), .i_Reset(rst_ext), .i_RX_Serial(rx8k),
        .o_RX_DV(dv8k), .o_RX_Byte(byte8k), .o_RX_Error(err8k), .o_RX_Busy(busy8k)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitors
    logic [7:0] got_q[$];
    int got_err16 = 0;
    int dv_cnt4 = 0, err_cnt4 = 0, dv_cnt8k = 0, err_cnt8k = 0;
    int both_hi = 0;
    logic [7:0] last4 = 8'h00, last8k = 8'h00;

    always @(negedge clk) begin
        if (dv16) got_q.push_back(byte16);
        if (err16) got_err16++;
        if (dv4) begin dv_cnt4++; last4 = byte4; end
        if (err4) err_cnt4++;
        if (dv8k) begin dv_cnt8k++; last8k = byte8k; end
        if (err8k) err_cnt8k++;
        if ((dv16 && err16) || (dv4 && err4) || (dv8k && err8k)) both_hi++;
    end

    // Frame-level reference model: a frame yields its byte if the stop bit is high, else one error
    logic [7:0] exp_q[$];
    int exp_err16 = 0;
    logic [7:0] exp_byte16 = 8'h00;

    function automatic void model_frame(input logic [7:0] d, input bit stop_ok);
        if (stop_ok) begin
            exp_q.push_back(d);
            exp_byte16 = d;
        end else begin
            exp_err16++;
        end
    endfunction

    function automatic int cpb(input int sel);
        case (sel)
            0:       return int'(C16);
            1:       return int'(C4);
            default: return int'(C8K);
        endcase
    endfunction

    task automatic drive(input int sel, input logic v, input int n);
        case (sel)
            0:       rx16 = v;
            1:       rx4  = v;
            default: rx8k = v;
        endcase
        repeat (n) @(negedge clk);
    endtask

    // Start bit plus eight data bits, LSB first; caller drives the stop level
    task automatic send_data(input int sel, input logic [7:0] d);
        drive(sel, 1'b0, cpb(sel));
        for (int i = 0; i < 8; i++) drive(sel, d[i], cpb(sel));
    endtask

    task automatic settle_check(input string tag);
        drive(0, 1'b1, 3 * int'(C16));
        check({tag, "_dv_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
        check({tag, "_err_count"}, 32'(got_err16), 32'(exp_err16));
        check({tag, "_held_byte"}, 32'(byte16), 32'(exp_byte16));
        check({tag, "_idle"}, 32'(busy16), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] c3;
        bit ok;

        rx16 = 1'b1; rx4 = 1'b1; rx8k = 1'b1;
        rst16 = 1'b1; rst_ext = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_byte", 32'(byte16), 32'd0);
        check("rst_dv", 32'(dv16), 32'd0);
        check("rst_err", 32'(err16), 32'd0);
        check("rst_busy", 32'(busy16), 32'd0);
        check("rst_byte_c4", 32'(byte4), 32'd0);
        rst16 = 1'b0; rst_ext = 1'b0;

        fork
            begin
                drive(2, 1'b1, 4);
                send_data(2, 8'h5A);
                drive(2, 1'b1, int'(C8K) * 3 / 5);
                check("c8191_dv_count", 32'(dv_cnt8k), 32'd1);
                check("c8191_byte", 32'(last8k), 32'h5A);
                check("c8191_out_byte", 32'(byte8k), 32'h5A);
                check("c8191_err_count", 32'(err_cnt8k), 32'd0);
                check("c8191_idle", 32'(busy8k), 32'd0);
            end
            begin
                drive(1, 1'b1, 4);
                send_data(1, 8'h5A);
                drive(1, 1'b1, 3 * int'(C4));
                check("c4_dv_count", 32'(dv_cnt4), 32'd1);
                check("c4_byte", 32'(last4), 32'h5A);
                check("c4_err_count", 32'(err_cnt4), 32'd0);
                check("c4_idle", 32'(busy4), 32'd0);

                drive(0, 1'b1, 8);
                send_data(0, 8'hA5);
                drive(0, 1'b1, int'(C16));
                model_frame(8'hA5, 1'b1);
                settle_check("a5");

                send_data(0, 8'h00);
                drive(0, 1'b1, int'(C16));
                send_data(0, 8'hFF);
                drive(0, 1'b1, int'(C16));
                model_frame(8'h00, 1'b1);
                model_frame(8'hFF, 1'b1);
                settle_check("b2b");

                drive(0, 1'b0, 4);
                drive(0, 1'b1, 1);
                check("glitch_seen_busy", 32'(busy16), 32'd1);
                settle_check("glitch");

                send_data(0, 8'h3C);
                drive(0, 1'b0, 3 * int'(C16));
                model_frame(8'h3C, 1'b0);
                check("ferr_pulse", 32'(got_err16), 32'(exp_err16));
                check("ferr_busy_low", 32'(busy16), 32'd1);
                drive(0, 1'b1, int'(C16));
                settle_check("ferr");
                send_data(0, 8'h55);
                drive(0, 1'b1, int'(C16));
                model_frame(8'h55, 1'b1);
                settle_check("after_ferr");

                c3 = 8'hC3;
                drive(0, 1'b0, int'(C16));
                for (int i = 0; i < 4; i++) drive(0, c3[i], int'(C16));
                drive(0, c3[4], int'(C16) / 2);
                rst16 = 1'b1;
                @(negedge clk);
                check("midrst_byte", 32'(byte16), 32'd0);
                check("midrst_dv", 32'(dv16), 32'd0);
                check("midrst_err", 32'(err16), 32'd0);
                check("midrst_busy", 32'(busy16), 32'd0);
                rst16 = 1'b0;
                exp_byte16 = 8'h00;
                settle_check("midrst");
                send_data(0, 8'h81);
                drive(0, 1'b1, int'(C16));
                model_frame(8'h81, 1'b1);
                settle_check("after_rst");

                for (int k = 0; k < 10; k++) begin
                    d  = 8'($urandom);
                    ok = ($urandom_range(3) != 0);
                    send_data(0, d);
                    if (ok) begin
                        drive(0, 1'b1, int'(C16) + int'($urandom_range(20)));
                    end else begin
                        drive(0, 1'b0, int'($urandom_range(2 * C16, C16)));
                        drive(0, 1'b1, int'($urandom_range(C16, 4)));
                    end
                    model_frame(d, ok);
                end
                settle_check("random");
            end
        join

        check("dv_err_overlap", 32'(both_hi), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
